// File: rtl/order_manager.sv
`default_nettype none
// ============================================================================
// Module : order_manager
// Round timer, four timed order slots, spawn/delivery/expiry and the score
// total for the kitchen game.
// Rev    : 1.0  initial release
// ============================================================================
module order_manager #(
    parameter int CLK_HZ         = 65_000_000,
    parameter int GAME_SECONDS   = 180,
    parameter int ORDER_LIFE     = 20,
    parameter int SPAWN_PERIOD   = 8,
    parameter int DELIVER_POINTS = 20,
    parameter int EXPIRE_PENALTY = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [2:0]      game_state,
    input  logic            deliver_valid,
    output logic            deliver_ack,
    output logic            deliver_hit,
    output logic [3:0]      orders,
    output logic [3:0][4:0] order_times,
    output logic [7:0]      time_left,
    output logic [9:0]      point_total,
    output logic            game_over
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SPN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    localparam logic [2:0]       c_GS_START = 3'd1;
    localparam logic [2:0]       c_GS_PLAY  = 3'd2;
    localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [SPN_W-1:0] c_SPN_LAST = SPN_W'(SPAWN_PERIOD - 1);
    localparam logic [4:0]       c_LIFE     = 5'(ORDER_LIFE);
    localparam logic [7:0]       c_ROUND    = 8'(GAME_SECONDS);

    logic [PRE_W-1:0] r_pre;
    logic [SPN_W-1:0] r_spawn_cnt;
    logic             r_spawn_pending;

    logic             w_run;
    logic             w_tick;
    logic             w_tgt_any;
    logic             w_free_any;
    logic             w_deliver;
    logic             w_spawn;
    logic [1:0]       w_tgt;
    logic [1:0]       w_free;
    logic [4:0]       w_tgt_time;
    logic [3:0]       w_orders_nxt;
    logic [3:0][4:0]  w_times_nxt;
    int               w_n_expire;
    int               w_score;
    logic [9:0]       w_score_sat;

    always_comb begin
        w_run  = (game_state == c_GS_PLAY) && !game_over;
        w_tick = w_run && (r_pre == c_PRE_LAST);

        // Strict '<' keeps the lowest index on equal remaining times.
        w_tgt_any  = 1'b0;
        w_tgt      = '0;
        w_tgt_time = '0;
        for (int i = 0; i < 4; i++) begin
            if (orders[i] && (!w_tgt_any || order_times[i] < w_tgt_time)) begin
                w_tgt_any  = 1'b1;
                w_tgt      = 2'(i);
                w_tgt_time = order_times[i];
            end
        end

        w_free_any = 1'b0;
        w_free     = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!orders[i]) begin
                w_free_any = 1'b1;
                w_free     = 2'(i);
            end
        end

        w_deliver = deliver_valid && w_run && w_tgt_any;
        w_spawn   = w_run && r_spawn_pending && w_free_any;

        w_orders_nxt = orders;
        w_times_nxt  = order_times;
        w_n_expire   = 0;
        for (int i = 0; i < 4; i++) begin
            if (w_deliver && w_tgt == 2'(i)) begin
                w_orders_nxt[i] = 1'b0;
                w_times_nxt[i]  = '0;
            end else if (w_tick && orders[i]) begin
                if (order_times[i] == 5'd1) begin
                    w_orders_nxt[i] = 1'b0;
                    w_times_nxt[i]  = '0;
                    w_n_expire      = w_n_expire + 1;
                end else begin
                    w_times_nxt[i] = order_times[i] - 5'd1;
                end
            end
            if (w_spawn && w_free == 2'(i)) begin
                w_orders_nxt[i] = 1'b1;
                w_times_nxt[i]  = c_LIFE;
            end
        end

        // Wide signed intermediate so 999 plus a bonus never wraps before the clamp.
        w_score = int'(point_total) - EXPIRE_PENALTY * w_n_expire
                + (w_deliver ? DELIVER_POINTS + int'(w_tgt_time) : 0);
        if (w_score < 0)
            w_score_sat = '0;
        else if (w_score > 999)
            w_score_sat = 10'd999;
        else
            w_score_sat = 10'(w_score);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre           <= '0;
            r_spawn_cnt     <= '0;
            r_spawn_pending <= 1'b0;
            orders          <= '0;
            order_times     <= '0;
            time_left       <= c_ROUND;
            point_total     <= '0;
            game_over       <= 1'b0;
            deliver_ack     <= 1'b0;
            deliver_hit     <= 1'b0;
        end else begin
            deliver_ack <= deliver_valid;
            deliver_hit <= w_deliver;
            if (game_state == c_GS_START) begin
                r_pre           <= '0;
                r_spawn_cnt     <= '0;
                r_spawn_pending <= 1'b1;
                orders          <= '0;
                order_times     <= '0;
                time_left       <= c_ROUND;
                point_total     <= '0;
                game_over       <= 1'b0;
            end else if (w_run) begin
                r_pre       <= w_tick ? '0 : r_pre + 1'b1;
                orders      <= w_orders_nxt;
                order_times <= w_times_nxt;
                point_total <= w_score_sat;
                if (w_tick) begin
                    if (time_left != 8'd0)
                        time_left <= time_left - 8'd1;
                    if (time_left == 8'd1)
                        game_over <= 1'b1;
                    r_spawn_cnt <= (r_spawn_cnt == c_SPN_LAST) ? '0 : r_spawn_cnt + 1'b1;
                end
                // A spawn consumes the request; a period boundary raises a new one.
                r_spawn_pending <= (r_spawn_pending && !w_spawn)
                                 || (w_tick && r_spawn_cnt == c_SPN_LAST);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_order_manager.sv
`default_nettype none
// ============================================================================
// Module : tb_order_manager
// Directed and randomized bench for order_manager with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_order_manager;
    localparam int CLK_HZ         = 4;
    localparam int GAME_SECONDS   = 180;
    localparam int ORDER_LIFE     = 20;
    localparam int SPAWN_PERIOD   = 2;
    localparam int DELIVER_POINTS = 20;
    localparam int EXPIRE_PENALTY = 10;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      game_state = 3'd0;
    logic            deliver_valid = 1'b0;
    logic            deliver_ack;
    logic            deliver_hit;
    logic [3:0]      orders;
    logic [3:0][4:0] order_times;
    logic [7:0]      time_left;
    logic [9:0]      point_total;
    logic            game_over;

    order_manager #(
        .CLK_HZ(CLK_HZ), .GAME_SECONDS(GAME_SECONDS), .ORDER_LIFE(ORDER_LIFE),
        .SPAWN_PERIOD(SPAWN_PERIOD), .DELIVER_POINTS(DELIVER_POINTS),
        .EXPIRE_PENALTY(EXPIRE_PENALTY)
    ) dut (
        .clock(clock), .reset(reset), .game_state(game_state),
        .deliver_valid(deliver_valid), .deliver_ack(deliver_ack),
        .deliver_hit(deliver_hit), .orders(orders), .order_times(order_times),
        .time_left(time_left), .point_total(point_total), .game_over(game_over)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: game state in plain integers.
    bit m_act[4];
    int m_t[4];
    int m_left, m_score, m_cyc, m_secs;
    bit m_over, m_pend, m_ack, m_hit;

    task automatic model_step(input int gs, input bit dv, input bit rst);
        bit tick;
        int tgt, free, pen, bonus;
        if (rst) begin
            foreach (m_act[i]) begin m_act[i] = 0; m_t[i] = 0; end
            m_left = GAME_SECONDS; m_score = 0; m_cyc = 0; m_secs = 0;
            m_over = 0; m_pend = 0; m_ack = 0; m_hit = 0;
            return;
        end
        m_ack = dv;
        m_hit = 0;
        if (gs == 1) begin
            foreach (m_act[i]) begin m_act[i] = 0; m_t[i] = 0; end
            m_left = GAME_SECONDS; m_score = 0; m_cyc = 0; m_secs = 0;
            m_over = 0; m_pend = 1;
            return;
        end
        if (gs != 2 || m_over) return;
        m_cyc++;
        tick = (m_cyc % CLK_HZ) == 0;
        tgt = -1;
        if (dv)
            for (int i = 0; i < 4; i++)
                if (m_act[i] && (tgt < 0 || m_t[i] < m_t[tgt])) tgt = i;
        free = -1;
        for (int i = 0; i < 4; i++)
            if (!m_act[i] && free < 0) free = i;
        pen = 0;
        bonus = 0;
        if (tgt >= 0) begin
            bonus = DELIVER_POINTS + m_t[tgt];
            m_act[tgt] = 0; m_t[tgt] = 0; m_hit = 1;
        end
        if (tick)
            for (int i = 0; i < 4; i++)
                if (m_act[i]) begin
                    if (m_t[i] == 1) begin m_act[i] = 0; m_t[i] = 0; pen += EXPIRE_PENALTY; end
                    else m_t[i]--;
                end
        if (m_pend && free >= 0) begin
            m_act[free] = 1; m_t[free] = ORDER_LIFE; m_pend = 0;
        end
        if (tick) begin
            if (m_left > 0) m_left--;
            if (m_left == 0) m_over = 1;
            m_secs++;
            if (m_secs % SPAWN_PERIOD == 0) m_pend = 1;
        end
        m_score = m_score - pen + bonus;
        if (m_score < 0) m_score = 0;
        if (m_score > 999) m_score = 999;
    endtask

    function automatic logic [44:0] exp_vec();
        logic [3:0] o;
        logic [3:0][4:0] t;
        for (int i = 0; i < 4; i++) begin o[i] = m_act[i]; t[i] = 5'(m_t[i]); end
        return {m_ack, m_hit, o, t, 8'(m_left), 10'(m_score), m_over};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [2:0] gs, input bit dv, input bit rst);
        @(negedge clock);
        game_state = gs; deliver_valid = dv; reset = rst;
        @(posedge clock);
        model_step(int'(gs), dv, rst);
        #1;
        chk("cycle", 64'({deliver_ack, deliver_hit, orders, order_times,
                          time_left, point_total, game_over}), 64'(exp_vec()));
    endtask

    int snap_left, snap_score;
    logic [3:0][4:0] snap_times;

    initial begin
        // Reset
        step(3'd0, 0, 1);
        step(3'd0, 0, 1);
        chk("reset_orders", 64'(orders), 64'd0);
        chk("reset_time", 64'(time_left), 64'd180);
        chk("reset_score", 64'(point_total), 64'd0);
        chk("reset_ack", 64'({deliver_ack, deliver_hit, game_over}), 64'd0);

        // START then first PLAY cycle spawns slot 0
        step(3'd1, 0, 0);
        step(3'd1, 0, 0);
        step(3'd2, 0, 0);
        chk("first_spawn", 64'(orders), 64'b0001);
        chk("first_time", 64'(order_times[0]), 64'd20);

        // 20 ticks: slot 0 expires at score 0 (floor); freed slot refilled next cycle
        for (int i = 0; i < 79; i++) step(3'd2, 0, 0);
        chk("expire_orders", 64'(orders), 64'b1110);
        chk("expire_floor", 64'(point_total), 64'd0);
        chk("time_after_20", 64'(time_left), 64'd160);
        step(3'd2, 0, 0);
        chk("refill_orders", 64'(orders), 64'b1111);
        chk("refill_time", 64'(order_times[0]), 64'd20);

        // Deliver: smallest time (slot 1 at 2) served for 22
        step(3'd2, 1, 0);
        chk("deliver_ack_hit", 64'({deliver_ack, deliver_hit}), 64'b11);
        chk("deliver_score", 64'(point_total), 64'd22);
        chk("deliver_slot", 64'(orders), 64'b1101);

        // Delivery on the tick where the target sits at 1: +21, no penalty
        for (int i = 0; i < 13; i++) step(3'd2, 0, 0);
        step(3'd2, 1, 0);
        chk("conflict_score", 64'(point_total), 64'd43);
        chk("conflict_slot", 64'(orders[2]), 64'd0);

        // Plain expiry with a non-zero score
        for (int i = 0; i < 8; i++) step(3'd2, 0, 0);
        chk("expire_penalty", 64'(point_total), 64'd33);
        chk("expire_slot", 64'(orders[3]), 64'd0);

        // PAUSE freezes everything, deliveries included
        snap_left = m_left;
        snap_score = m_score;
        for (int i = 0; i < 4; i++) snap_times[i] = 5'(m_t[i]);
        for (int i = 0; i < 100; i++) step(3'd3, ($urandom_range(0, 3) == 0), 0);
        chk("pause_time", 64'(time_left), 64'(snap_left));
        chk("pause_slots", 64'(order_times), 64'(snap_times));
        chk("pause_score", 64'(point_total), 64'(snap_score));

        // Randomized play to the end of the round
        for (int i = 0; i < 2000 && !m_over; i++) begin
            logic [2:0] gs;
            gs = 3'd2;
            if ($urandom_range(0, 19) == 0) gs = 3'($urandom_range(3, 7));
            if (gs == 3'd1 || gs == 3'd2) gs = 3'd0;
            if ($urandom_range(0, 19) != 0) gs = 3'd2;
            step(gs, ($urandom_range(0, 3) == 0), 0);
        end
        chk("round_over", 64'({game_over, time_left}), 64'h100);

        // Delivery after game over is a miss
        snap_score = m_score;
        step(3'd2, 1, 0);
        chk("over_miss", 64'({deliver_ack, deliver_hit}), 64'b10);
        chk("over_score", 64'(point_total), 64'(snap_score));

        // START clears state
        step(3'd1, 0, 0);
        step(3'd1, 0, 0);
        chk("restart", 64'({orders, order_times, time_left, point_total, game_over}),
            64'({4'd0, 20'd0, 8'd180, 10'd0, 1'b0}));

        // Continuous delivery saturates the score
        for (int i = 0; i < 400; i++) step(3'd2, 1, 0);
        chk("saturate", 64'(point_total), 64'd999);
        for (int i = 0; i < 40; i++) step(3'd2, ($urandom_range(0, 1) == 1), 0);
        chk("saturate_hold", 64'(point_total), 64'd999);

        // Reset mid-round overrides a delivery
        step(3'd2, 1, 1);
        chk("mid_reset", 64'({deliver_ack, orders, time_left, point_total}),
            64'({1'b0, 4'd0, 8'd180, 10'd0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
